// File: rtl/link_supervisor_pkg.sv
`default_nettype none
// ============================================================================
// Module : link_supervisor_pkg
// Desc   : State encodings and timer-load helpers for the link supervisor.
// Rev    : 1.0 - initial release
// ============================================================================
package link_supervisor_pkg;

  typedef enum logic [2:0] {
    LS_IDLE      = 3'd0,
    LS_HANDSHAKE = 3'd1,
    LS_LINKED    = 3'd2,
    LS_BACKOFF   = 3'd3,
    LS_FAULT     = 3'd4
  } ls_state_e;

  function automatic logic [63:0] ls_max(input int tw);
    if (tw >= 64) return '1;
    return (64'd1 << tw) - 64'd1;
  endfunction

  // Zero loads become 1 so the timer always produces an expiry
  function automatic logic [63:0] ls_clamp(input logic [63:0] val, input int tw);
    logic [63:0] maxv;
    maxv = ls_max(tw);
    if (val == 64'd0) return 64'd1;
    if (val > maxv) return maxv;
    return val;
  endfunction

  function automatic logic [63:0] ls_backoff(input logic [63:0] base, input int shift,
                                             input int tw);
    logic [63:0] maxv;
    logic [63:0] v;
    maxv = ls_max(tw);
    v    = ls_clamp(base, tw);
    for (int k = 0; k < 64; k++) begin
      if (k < shift) begin
        if (v > (maxv >> 1)) v = maxv;
        else                 v = v << 1;
      end
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/link_supervisor_if.sv
`default_nettype none
// ============================================================================
// Module : link_supervisor_if
// Desc   : Application/MHP-side control and status bundle of the link supervisor.
// Rev    : 1.0 - initial release
// ============================================================================
interface link_supervisor_if #(
  parameter int MAX_RETRY = 4,
  parameter int CW        = 16
);
  localparam int RW = $clog2(MAX_RETRY + 1);

  logic          i_en;
  logic          i_done;
  logic          i_rx_act;
  logic          i_clr_fault;
  logic          o_send;
  logic          o_link;
  logic          o_fault;
  logic [2:0]    o_state;
  logic [RW-1:0] o_retry;
  logic [CW-1:0] o_drop_cnt;

  modport master (
    output i_en, i_done, i_rx_act, i_clr_fault,
    input  o_send, o_link, o_fault, o_state, o_retry, o_drop_cnt
  );

  modport slave (
    input  i_en, i_done, i_rx_act, i_clr_fault,
    output o_send, o_link, o_fault, o_state, o_retry, o_drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/link_supervisor_cyc_timer.sv
`default_nettype none
// ============================================================================
// Module : link_supervisor_cyc_timer
// Desc   : Loadable down-counter; o_expired flags the final count of a load.
// Rev    : 1.0 - initial release
// ============================================================================
module link_supervisor_cyc_timer #(
  parameter int TW = 24
) (
  input  wire          i_clk,
  input  wire          i_rst,
  input  wire          i_clr,
  input  wire          i_load,
  input  wire [TW-1:0] i_load_val,
  output logic         o_expired
);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= (i_load_val == '0) ? TW'(1) : i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - TW'(1);
    end
  end

  // A load of N expires N cycles after the load takes effect
  assign o_expired = (r_cnt == TW'(1));

endmodule
`default_nettype wire

// File: rtl/link_supervisor.sv
`default_nettype none
// ============================================================================
// Module : link_supervisor
// Desc   : Link-control FSM with attempt timeout, bounded retry/backoff and watchdog.
// Rev    : 1.0 - initial release
// ============================================================================
module link_supervisor
  import link_supervisor_pkg::*;
#(
  parameter int MODE        = 0,
  parameter int TW          = 24,
  parameter int TIMEOUT_CYC = 50000,
  parameter int MAX_RETRY   = 4,
  parameter int BACKOFF_CYC = 1000,
  parameter int WDOG_CYC    = 200000,
  parameter int CW          = 16
) (
  input wire               i_clk,
  input wire               i_rst,
  link_supervisor_if.slave bus
);

  localparam int            RW          = $clog2(MAX_RETRY + 1);
  localparam int            NBO         = 2 ** RW;
  localparam logic [TW-1:0] c_timeout   = TW'(ls_clamp(64'(TIMEOUT_CYC), TW));
  localparam logic [TW-1:0] c_wdog      = TW'(ls_clamp(64'(WDOG_CYC), TW));
  localparam logic [RW-1:0] c_max_retry = RW'(MAX_RETRY);

  ls_state_e     r_state;
  ls_state_e     w_nxt;
  logic          r_send;
  logic          r_link;
  logic          r_fault;
  logic [RW-1:0] r_retry;
  logic [CW-1:0] r_drop;

  logic          w_send;
  logic          w_load;
  logic          w_clr;
  logic          w_drop;
  logic          w_expired;
  logic [TW-1:0] w_load_val;
  logic [RW-1:0] w_retry_nxt;
  logic [RW-1:0] w_retry_inc;
  logic [TW-1:0] w_bo_tbl [NBO];

  // Backoff for attempt n is precomputed; indexed by failures so far
  for (genvar gi = 0; gi < NBO; gi++) begin : g_bo
    assign w_bo_tbl[gi] = TW'(ls_backoff(64'(BACKOFF_CYC), gi, TW));
  end

  assign w_retry_inc = r_retry + RW'(1);

  always_comb begin
    w_nxt       = r_state;
    w_send      = 1'b0;
    w_load      = 1'b0;
    w_load_val  = c_timeout;
    w_retry_nxt = r_retry;
    w_drop      = 1'b0;
    if (!bus.i_en && (r_state != LS_FAULT)) begin
      w_nxt       = LS_IDLE;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        LS_IDLE: begin
          if ((MODE != 0) || bus.i_done) begin
            w_nxt  = LS_HANDSHAKE;
            w_send = 1'b1;
            w_load = 1'b1;
          end
        end
        LS_HANDSHAKE: begin
          if (bus.i_done) begin
            w_nxt       = LS_LINKED;
            w_retry_nxt = '0;
            w_load      = 1'b1;
            w_load_val  = c_wdog;
          end else if (w_expired) begin
            w_retry_nxt = w_retry_inc;
            if (w_retry_inc == c_max_retry) begin
              w_nxt = LS_FAULT;
            end else begin
              w_nxt      = LS_BACKOFF;
              w_load     = 1'b1;
              w_load_val = w_bo_tbl[r_retry];
            end
          end
        end
        LS_LINKED: begin
          if (bus.i_done) begin
            w_nxt  = LS_HANDSHAKE;
            w_send = 1'b1;
            w_load = 1'b1;
          end else if (bus.i_rx_act) begin
            w_load     = 1'b1;
            w_load_val = c_wdog;
          end else if (w_expired) begin
            w_nxt      = LS_BACKOFF;
            w_drop     = 1'b1;
            w_load     = 1'b1;
            w_load_val = w_bo_tbl[0];
          end
        end
        LS_BACKOFF: begin
          if (w_expired) begin
            w_nxt  = LS_HANDSHAKE;
            w_send = 1'b1;
            w_load = 1'b1;
          end
        end
        LS_FAULT: begin
          if (bus.i_clr_fault) begin
            w_nxt       = LS_IDLE;
            w_retry_nxt = '0;
          end
        end
        default: begin
          w_nxt       = LS_IDLE;
          w_retry_nxt = '0;
        end
      endcase
    end
  end

  // Parked states hold the timer at zero so no stale expiry survives
  assign w_clr = (w_nxt == LS_IDLE) || (w_nxt == LS_FAULT);

  link_supervisor_cyc_timer #(
    .TW (TW)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (w_clr),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_expired  (w_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= LS_IDLE;
      r_send  <= 1'b0;
      r_link  <= 1'b0;
      r_fault <= 1'b0;
      r_retry <= '0;
      r_drop  <= '0;
    end else begin
      r_state <= w_nxt;
      r_send  <= w_send;
      r_link  <= (r_state == LS_LINKED) && (w_nxt == LS_LINKED);
      r_fault <= (w_nxt == LS_FAULT);
      r_retry <= w_retry_nxt;
      if (w_drop && (r_drop != '1)) begin
        r_drop <= r_drop + CW'(1);
      end
    end
  end

  assign bus.o_send     = r_send;
  assign bus.o_link     = r_link;
  assign bus.o_fault    = r_fault;
  assign bus.o_state    = r_state;
  assign bus.o_retry    = r_retry;
  assign bus.o_drop_cnt = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_link_supervisor.sv
`default_nettype none
// ============================================================================
// Module : tb_link_supervisor
// Desc   : Self-checking bench for link_supervisor (initiator and responder).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_link_supervisor;
  import link_supervisor_pkg::*;

  localparam int TW = 8;
  localparam int TO = 16;
  localparam int MR = 3;
  localparam int BO = 8;
  localparam int WD = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_send1[$];
  int   exp_send0[$];
  int   e1;
  int   e0;

  link_supervisor_if #(.MAX_RETRY(MR), .CW(CW)) bus1 ();
  link_supervisor_if #(.MAX_RETRY(MR), .CW(CW)) bus0 ();

  link_supervisor #(
    .MODE(1), .TW(TW), .TIMEOUT_CYC(TO), .MAX_RETRY(MR),
    .BACKOFF_CYC(BO), .WDOG_CYC(WD), .CW(CW)
  ) u_dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus1)
  );

  link_supervisor #(
    .MODE(0), .TW(TW), .TIMEOUT_CYC(TO), .MAX_RETRY(MR),
    .BACKOFF_CYC(BO), .WDOG_CYC(WD), .CW(CW)
  ) u_dut0 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every o_send pulse must match the next cycle queued by the stimulus
  always @(negedge clk) begin
    if (bus1.o_send === 1'b1) begin
      n_checks++;
      if (exp_send1.size() == 0) begin
        n_fail++;
        $display("FAIL send1_unexpected: o_send=1 at cycle %0d, required none", cyc);
      end else begin
        e1 = exp_send1.pop_front();
        if (cyc != e1) begin
          n_fail++;
          $display("FAIL send1_cycle: o_send at cycle %0d, required cycle %0d", cyc, e1);
        end
      end
    end
    if (bus0.o_send === 1'b1) begin
      n_checks++;
      if (exp_send0.size() == 0) begin
        n_fail++;
        $display("FAIL send0_unexpected: o_send=1 at cycle %0d, required none", cyc);
      end else begin
        e0 = exp_send0.pop_front();
        if (cyc != e0) begin
          n_fail++;
          $display("FAIL send0_cycle: o_send at cycle %0d, required cycle %0d", cyc, e0);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus1.i_en = 1'b0; bus1.i_done = 1'b0; bus1.i_rx_act = 1'b0; bus1.i_clr_fault = 1'b0;
    bus0.i_en = 1'b0; bus0.i_done = 1'b0; bus0.i_rx_act = 1'b0; bus0.i_clr_fault = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    bus1.i_en = 1'b1;
    tick(3);
    n_checks++;
    if (bus1.o_state !== LS_IDLE) begin
      n_fail++; $display("FAIL rst_state: got %0d required %0d", bus1.o_state, LS_IDLE);
    end
    n_checks++;
    if (bus1.o_send !== 1'b0) begin
      n_fail++; $display("FAIL rst_send: got %0b required 0", bus1.o_send);
    end
    n_checks++;
    if (bus1.o_link !== 1'b0 || bus1.o_fault !== 1'b0) begin
      n_fail++; $display("FAIL rst_link_fault: got %0b%0b required 00", bus1.o_link, bus1.o_fault);
    end
    n_checks++;
    if (bus1.o_retry !== '0 || bus1.o_drop_cnt !== '0) begin
      n_fail++; $display("FAIL rst_counts: got retry %0d drop %0d required 0 0",
                         bus1.o_retry, bus1.o_drop_cnt);
    end
    n_checks++;
    if ({bus0.o_send, bus0.o_link, bus0.o_fault, bus0.o_state, bus0.o_retry, bus0.o_drop_cnt} !== '0) begin
      n_fail++; $display("FAIL rst_dut0: got state %0d send %0b required all zero",
                         bus0.o_state, bus0.o_send);
    end
    rst = 1'b0;
    bus1.i_en = 1'b0;
  endtask

  task automatic test_connect();
    int t0;
    do_reset();
    t0 = cyc;
    bus1.i_en = 1'b1;
    exp_send1.push_back(t0 + 1);
    tick(1);
    n_checks++;
    if (bus1.o_state !== LS_HANDSHAKE) begin
      n_fail++; $display("FAIL conn_hs: got %0d required %0d", bus1.o_state, LS_HANDSHAKE);
    end
    tick(4);
    bus1.i_done = 1'b1;
    tick(1);
    bus1.i_done = 1'b0;
    n_checks++;
    if (bus1.o_state !== LS_LINKED || bus1.o_link !== 1'b0) begin
      n_fail++; $display("FAIL conn_entry: got state %0d link %0b required %0d 0",
                         bus1.o_state, bus1.o_link, LS_LINKED);
    end
    tick(1);
    n_checks++;
    if (bus1.o_link !== 1'b1 || bus1.o_retry !== '0) begin
      n_fail++; $display("FAIL conn_link: got link %0b retry %0d required 1 0",
                         bus1.o_link, bus1.o_retry);
    end
    n_checks++;
    if (exp_send1.size() != 0) begin
      n_fail++; $display("FAIL conn_pending: got %0d sends missing required 0", exp_send1.size());
    end
  endtask

  task automatic test_watchdog();
    int a;
    a = cyc;
    for (int i = 0; i < 10; i++) begin
      a = cyc;
      bus1.i_rx_act = 1'b1;
      tick(1);
      bus1.i_rx_act = 1'b0;
      tick(19);
      n_checks++;
      if (bus1.o_link !== 1'b1) begin
        n_fail++; $display("FAIL wdog_hold: got link %0b at cycle %0d required 1", bus1.o_link, cyc);
      end
    end
    exp_send1.push_back(a + 41);
    tick(12);
    n_checks++;
    if (bus1.o_link !== 1'b1 || bus1.o_state !== LS_LINKED) begin
      n_fail++; $display("FAIL wdog_early: got link %0b state %0d required 1 %0d",
                         bus1.o_link, bus1.o_state, LS_LINKED);
    end
    tick(1);
    n_checks++;
    if (bus1.o_link !== 1'b0 || bus1.o_state !== LS_BACKOFF || bus1.o_drop_cnt !== CW'(1)) begin
      n_fail++; $display("FAIL wdog_drop: got link %0b state %0d drop %0d required 0 %0d 1",
                         bus1.o_link, bus1.o_state, bus1.o_drop_cnt, LS_BACKOFF);
    end
    tick(8);
    n_checks++;
    if (bus1.o_state !== LS_HANDSHAKE) begin
      n_fail++; $display("FAIL wdog_rehs: got %0d required %0d", bus1.o_state, LS_HANDSHAKE);
    end
    bus1.i_done = 1'b1;
    tick(1);
    bus1.i_done = 1'b0;
    n_checks++;
    if (bus1.o_state !== LS_LINKED) begin
      n_fail++; $display("FAIL wdog_relink: got %0d required %0d", bus1.o_state, LS_LINKED);
    end
  endtask

  task automatic test_done_vs_wdog();
    int l;
    l = cyc;
    tick(31);
    n_checks++;
    if (bus1.o_link !== 1'b1) begin
      n_fail++; $display("FAIL dvw_pre: got link %0b required 1", bus1.o_link);
    end
    bus1.i_done = 1'b1;
    exp_send1.push_back(l + 32);
    tick(1);
    bus1.i_done = 1'b0;
    n_checks++;
    if (bus1.o_state !== LS_HANDSHAKE || bus1.o_link !== 1'b0 || bus1.o_drop_cnt !== CW'(1)) begin
      n_fail++; $display("FAIL dvw_take: got state %0d link %0b drop %0d required %0d 0 1",
                         bus1.o_state, bus1.o_link, bus1.o_drop_cnt, LS_HANDSHAKE);
    end
    bus1.i_en = 1'b0;
    tick(1);
    n_checks++;
    if (bus1.o_state !== LS_IDLE || exp_send1.size() != 0) begin
      n_fail++; $display("FAIL dvw_end: got state %0d pending %0d required %0d 0",
                         bus1.o_state, exp_send1.size(), LS_IDLE);
    end
  endtask

  task automatic test_retry_fault();
    int t0;
    do_reset();
    t0 = cyc;
    bus1.i_en = 1'b1;
    exp_send1.push_back(t0 + 1);
    exp_send1.push_back(t0 + 25);
    exp_send1.push_back(t0 + 57);
    tick(17);
    n_checks++;
    if (bus1.o_state !== LS_BACKOFF || bus1.o_retry !== 2'd1) begin
      n_fail++; $display("FAIL rf_bo1: got state %0d retry %0d required %0d 1",
                         bus1.o_state, bus1.o_retry, LS_BACKOFF);
    end
    tick(24);
    n_checks++;
    if (bus1.o_state !== LS_BACKOFF || bus1.o_retry !== 2'd2) begin
      n_fail++; $display("FAIL rf_bo2: got state %0d retry %0d required %0d 2",
                         bus1.o_state, bus1.o_retry, LS_BACKOFF);
    end
    tick(31);
    n_checks++;
    if (bus1.o_state !== LS_HANDSHAKE || bus1.o_fault !== 1'b0) begin
      n_fail++; $display("FAIL rf_prefault: got state %0d fault %0b required %0d 0",
                         bus1.o_state, bus1.o_fault, LS_HANDSHAKE);
    end
    tick(1);
    n_checks++;
    if (bus1.o_state !== LS_FAULT || bus1.o_fault !== 1'b1 || bus1.o_retry !== 2'd3) begin
      n_fail++; $display("FAIL rf_fault: got state %0d fault %0b retry %0d required %0d 1 3",
                         bus1.o_state, bus1.o_fault, bus1.o_retry, LS_FAULT);
    end
    for (int i = 0; i < 4; i++) begin
      bus1.i_done = 1'b1;
      bus1.i_rx_act = 1'b1;
      tick(1);
      bus1.i_done = 1'b0;
      bus1.i_rx_act = 1'b0;
      tick(9);
    end
    bus1.i_en = 1'b0;
    tick(2);
    n_checks++;
    if (bus1.o_state !== LS_FAULT || bus1.o_fault !== 1'b1) begin
      n_fail++; $display("FAIL rf_sticky: got state %0d fault %0b required %0d 1",
                         bus1.o_state, bus1.o_fault, LS_FAULT);
    end
    bus1.i_clr_fault = 1'b1;
    tick(1);
    bus1.i_clr_fault = 1'b0;
    n_checks++;
    if (bus1.o_state !== LS_IDLE || bus1.o_fault !== 1'b0 || bus1.o_retry !== '0) begin
      n_fail++; $display("FAIL rf_clear: got state %0d fault %0b retry %0d required %0d 0 0",
                         bus1.o_state, bus1.o_fault, bus1.o_retry, LS_IDLE);
    end
    n_checks++;
    if (exp_send1.size() != 0) begin
      n_fail++; $display("FAIL rf_pending: got %0d sends missing required 0", exp_send1.size());
    end
  endtask

  task automatic test_responder();
    int t;
    do_reset();
    bus0.i_en = 1'b1;
    tick(1000);
    n_checks++;
    if (bus0.o_state !== LS_IDLE) begin
      n_fail++; $display("FAIL resp_idle: got %0d required %0d", bus0.o_state, LS_IDLE);
    end
    t = cyc;
    bus0.i_done = 1'b1;
    exp_send0.push_back(t + 1);
    tick(1);
    bus0.i_done = 1'b0;
    n_checks++;
    if (bus0.o_state !== LS_HANDSHAKE || bus0.o_send !== 1'b1) begin
      n_fail++; $display("FAIL resp_reply: got state %0d send %0b required %0d 1",
                         bus0.o_state, bus0.o_send, LS_HANDSHAKE);
    end
    bus0.i_en = 1'b0;
    tick(1);
    n_checks++;
    if (bus0.o_state !== LS_IDLE || exp_send0.size() != 0) begin
      n_fail++; $display("FAIL resp_end: got state %0d pending %0d required %0d 0",
                         bus0.o_state, exp_send0.size(), LS_IDLE);
    end
  endtask

  task automatic test_abort();
    int t0;
    do_reset();
    t0 = cyc;
    bus1.i_en = 1'b1;
    exp_send1.push_back(t0 + 1);
    tick(2);
    bus1.i_done = 1'b1;
    tick(1);
    bus1.i_done = 1'b0;
    tick(32);
    n_checks++;
    if (bus1.o_state !== LS_BACKOFF || bus1.o_drop_cnt !== CW'(1)) begin
      n_fail++; $display("FAIL ab_drop: got state %0d drop %0d required %0d 1",
                         bus1.o_state, bus1.o_drop_cnt, LS_BACKOFF);
    end
    tick(1);
    bus1.i_en = 1'b0;
    tick(1);
    n_checks++;
    if ({bus1.o_send, bus1.o_link, bus1.o_fault, bus1.o_state, bus1.o_retry} !== '0
        || bus1.o_drop_cnt !== CW'(1)) begin
      n_fail++; $display("FAIL ab_en_low: got state %0d link %0b drop %0d required %0d 0 1",
                         bus1.o_state, bus1.o_link, bus1.o_drop_cnt, LS_IDLE);
    end
    bus1.i_en = 1'b1;
    exp_send1.push_back(cyc + 1);
    tick(17);
    n_checks++;
    if (bus1.o_state !== LS_BACKOFF || bus1.o_retry !== 2'd1) begin
      n_fail++; $display("FAIL ab_bo: got state %0d retry %0d required %0d 1",
                         bus1.o_state, bus1.o_retry, LS_BACKOFF);
    end
    tick(1);
    rst = 1'b1;
    tick(1);
    n_checks++;
    if ({bus1.o_send, bus1.o_link, bus1.o_fault, bus1.o_state, bus1.o_retry, bus1.o_drop_cnt} !== '0) begin
      n_fail++; $display("FAIL ab_rst: got state %0d retry %0d drop %0d required all zero",
                         bus1.o_state, bus1.o_retry, bus1.o_drop_cnt);
    end
    rst = 1'b0;
    bus1.i_en = 1'b0;
    tick(20);
    n_checks++;
    if (bus1.o_state !== LS_IDLE || exp_send1.size() != 0) begin
      n_fail++; $display("FAIL ab_end: got state %0d pending %0d required %0d 0",
                         bus1.o_state, exp_send1.size(), LS_IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_connect();
    test_watchdog();
    test_done_vs_wdog();
    test_retry_fault();
    test_responder();
    test_abort();
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
